floo_route_comp_arb: RTL

FLOO_ROUTE_COMP_ARB -- requirements
Module: floo_route_comp_arb

---
 rtl/floo_pkg.sv | 31 +++
 rtl/floo_route_comp_arb_if.sv | 25 ++
 rtl/floo_route_lookup.sv | 49 ++++
 rtl/floo_route_comp_arb.sv | 134 +++++++++++++
 4 files changed

// File: rtl/floo_pkg.sv
// Shared routing types for the FlooNoC route-compute block: algorithm selector,
// rule typedef template, channel limit and a parameter legality helper.
`ifndef FLOO_PKG_SV
`define FLOO_PKG_SV

// Rule layout shared by every address map: {idx, start_addr, end_addr}.
`define FLOO_TYPEDEF_ID_RULE_T(__name, __id_t, __addr_t) \
  typedef struct packed { __id_t idx; __addr_t start_addr; __addr_t end_addr; } __name

package floo_pkg;

  typedef enum logic [1:0] {
    IdTable       = 2'd0,
    XYRouting     = 2'd1,
    SourceRouting = 2'd2
  } route_algo_e;

  localparam int unsigned MaxChannels = 16;
  localparam int unsigned ErrCntW     = 16;

  `FLOO_TYPEDEF_ID_RULE_T(default_id_rule_t, logic, logic);

  function automatic bit route_cfg_legal(route_algo_e algo, int unsigned num_ch,
                                         int unsigned num_rules);
    return ((algo == IdTable) || (algo == XYRouting)) &&
           (num_ch >= 1) && (num_ch <= MaxChannels) && (num_rules >= 1);
  endfunction

endpackage

`endif

// File: rtl/floo_route_comp_arb_if.sv
// Request/result bundle between the channel owners and floo_route_comp_arb.
interface floo_route_comp_arb_if #(
  parameter int unsigned NumChannels = 4,
  parameter type         addr_t      = logic,
  parameter type         id_t        = logic
);
  logic  [NumChannels-1:0] valid_i;
  logic  [NumChannels-1:0] ready_o;
  addr_t [NumChannels-1:0] addr_i;
  logic  [NumChannels-1:0] valid_o;
  logic  [NumChannels-1:0] ready_i;
  id_t   [NumChannels-1:0] id_o;
  logic  [NumChannels-1:0] dec_err_o;
  logic  [15:0]            err_cnt_o;

  modport master (
    output valid_i, addr_i, ready_i,
    input  ready_o, valid_o, id_o, dec_err_o, err_cnt_o
  );

  modport slave (
    input  valid_i, addr_i, ready_i,
    output ready_o, valid_o, id_o, dec_err_o, err_cnt_o
  );
endinterface

// File: rtl/floo_route_lookup.sv
// Combinational destination lookup: address-table search or direct XY / ID bit
// extraction from the request address.
module floo_route_lookup
  import floo_pkg::*;
#(
  parameter route_algo_e RouteAlgo     = IdTable,
  parameter bit          UseIdTable    = 1'b1,
  parameter int unsigned XYAddrOffsetX = 0,
  parameter int unsigned XYAddrOffsetY = 0,
  parameter int unsigned IdAddrOffset  = 0,
  parameter int unsigned NumRules      = 1,
  parameter type         id_t          = logic,
  parameter type         id_rule_t     = default_id_rule_t,
  parameter type         addr_t        = logic,
  parameter id_rule_t [NumRules-1:0] AddrMap = '0
) (
  input  addr_t addr_i,
  output id_t   id_o,
  output logic  dec_err_o
);

  if (UseIdTable) begin : g_table
    logic w_found;
    // Lowest-numbered matching rule wins when ranges overlap.
    always_comb begin
      id_o    = '0;
      w_found = 1'b0;
      for (int unsigned r = 0; r < NumRules; r++) begin
        if (!w_found && (addr_i >= addr_t'(AddrMap[r].start_addr)) &&
            (addr_i < addr_t'(AddrMap[r].end_addr))) begin
          id_o    = id_t'(AddrMap[r].idx);
          w_found = 1'b1;
        end
      end
    end
    assign dec_err_o = ~w_found;
  end else if (RouteAlgo == XYRouting) begin : g_xy
    always_comb begin
      id_o   = '0;
      id_o.x = addr_i[XYAddrOffsetX +: $bits(id_o.x)];
      id_o.y = addr_i[XYAddrOffsetY +: $bits(id_o.y)];
    end
    assign dec_err_o = 1'b0;
  end else begin : g_id
    assign id_o      = id_t'(addr_i[IdAddrOffset +: $bits(id_t)]);
    assign dec_err_o = 1'b0;
  end

endmodule

// File: rtl/floo_route_comp_arb.sv
// Multi-channel route computation: round-robin arbitration onto one shared lookup,
// one registered result slot per channel. Optional decode-error counter is built
// only when FLOO_ROUTE_COMP_ERR_CNT_EN is defined.
module floo_route_comp_arb
  import floo_pkg::*;
#(
  parameter route_algo_e RouteAlgo     = IdTable,
  parameter bit          UseIdTable    = 1'b1,
  parameter int unsigned XYAddrOffsetX = 0,
  parameter int unsigned XYAddrOffsetY = 0,
  parameter int unsigned IdAddrOffset  = 0,
  parameter int unsigned NumRules      = 1,
  parameter int unsigned NumChannels   = 4,
  parameter type         id_t          = logic,
  parameter type         id_rule_t     = default_id_rule_t,
  parameter type         addr_t        = logic,
  parameter id_rule_t [NumRules-1:0] AddrMap = '0
) (
  input logic                  clk_i,
  input logic                  rst_i,
  floo_route_comp_arb_if.slave bus
);

  if (!route_cfg_legal(RouteAlgo, NumChannels, NumRules)) begin : g_bad_cfg
    $fatal(1, "floo_route_comp_arb: illegal RouteAlgo/NumChannels/NumRules");
  end

  localparam int unsigned IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  logic  [NumChannels-1:0] w_elig;
  logic  [NumChannels-1:0] w_gnt;
  logic  [NumChannels-1:0] r_vld;
  logic  [NumChannels-1:0] r_err;
  id_t   [NumChannels-1:0] r_id;
  logic  [IdxW-1:0]        r_prio;
  logic  [IdxW-1:0]        w_gnt_idx;
  logic  [IdxW-1:0]        w_cand;
  logic  [IdxW-1:0]        w_prio_nxt;
  logic                    w_found;
  logic                    w_accept;
  addr_t                   w_addr;
  id_t                     w_lkp_id;
  logic                    w_lkp_err;

  // A full slot may accept only when it drains in the same cycle.
  assign w_elig = bus.valid_i & (~r_vld | bus.ready_i);

  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_found   = 1'b0;
    for (int unsigned k = 0; k < NumChannels; k++) begin
      w_cand = IdxW'((32'(r_prio) + k) % NumChannels);
      if (!w_found && w_elig[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (w_found && !rst_i) begin
      w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  assign w_accept    = |w_gnt;
  assign w_prio_nxt  = (w_gnt_idx == IdxW'(NumChannels - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_addr      = bus.addr_i[w_gnt_idx];
  assign bus.ready_o = w_gnt;

  floo_route_lookup #(
    .RouteAlgo    (RouteAlgo),
    .UseIdTable   (UseIdTable),
    .XYAddrOffsetX(XYAddrOffsetX),
    .XYAddrOffsetY(XYAddrOffsetY),
    .IdAddrOffset (IdAddrOffset),
    .NumRules     (NumRules),
    .id_t         (id_t),
    .id_rule_t    (id_rule_t),
    .addr_t       (addr_t),
    .AddrMap      (AddrMap)
  ) u_lookup (
    .addr_i   (w_addr),
    .id_o     (w_lkp_id),
    .dec_err_o(w_lkp_err)
  );

  // Result slots and arbitration pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld  <= '0;
      r_err  <= '0;
      r_id   <= '0;
      r_prio <= '0;
    end else begin
      if (w_accept) begin
        r_prio <= w_prio_nxt;
      end
      for (int unsigned i = 0; i < NumChannels; i++) begin
        if (w_gnt[i]) begin
          r_vld[i] <= 1'b1;
          r_id[i]  <= w_lkp_id;
          r_err[i] <= w_lkp_err;
        end else if (bus.ready_i[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.valid_o   = r_vld;
  assign bus.id_o      = r_id;
  assign bus.dec_err_o = r_err;

`ifdef FLOO_ROUTE_COMP_ERR_CNT_EN
  function automatic logic [ErrCntW-1:0] sat_inc(input logic [ErrCntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [ErrCntW-1:0] r_err_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_lkp_err) begin
      r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign bus.err_cnt_o = r_err_cnt;
`else
  assign bus.err_cnt_o = '0;
`endif

endmodule
